float_to_int_converter: RTL and testbench

Downstream consumer of the float adder result. Takes a 32-bit IEEE-754 single (`in_z`) and the adder's 2-bit overflow code (`in_flag`), and converts it to a two's-complement signed integer using round-to-nearest-even. It is iterative: one mantissa shift per cycle. Both sides use a valid/ready handshake, so the block can sit between the adder result register and an integer datapath.

---
 rtl/float_to_int_if.sv | 25 ++
 rtl/float_to_int_converter.sv | 167 ++++++++++++++++
 tb/tb_float_to_int_converter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/float_to_int_if.sv
// rtl/float_to_int_if.sv - valid/ready bundle between float producer, converter and integer consumer
interface float_to_int_if #(
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_z;
  logic [1:0]       in_flag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_int;
  logic [1:0]       out_status;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, in_z, in_flag, out_ready,
    input  in_ready, out_valid, out_int, out_status
  );

  // Converter side.
  modport slave (
    input  in_valid, in_z, in_flag, out_ready,
    output in_ready, out_valid, out_int, out_status
  );
endinterface

// File: rtl/float_to_int_converter.sv
// rtl/float_to_int_converter.sv - iterative IEEE-754 single to signed integer, round-to-nearest-even
module float_to_int_converter #(
  parameter int OUT_W = 32
) (
  input logic           clk,
  input logic           rst,
  float_to_int_if.slave bus
);
  localparam int MW = OUT_W + 1;
  localparam logic signed [9:0] E_TOP = 10'(OUT_W - 1);
  localparam logic signed [9:0] E_23  = 10'sd23;

  typedef enum logic [2:0] {S_IDLE, S_CLASSIFY, S_SHIFT, S_ROUND, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      z_q, z_d;
  logic [MW-1:0]    mag_q, mag_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic             left_q, left_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_int_q, out_int_d;
  logic [1:0]       out_status_q, out_status_d;

  // Fields of the captured operand; the adder flag is informational only,
  // so classification looks purely at these bits.
  logic              sign_w;
  logic [7:0]        exp_w;
  logic [22:0]       frac_w;
  logic signed [9:0] e_w;
  logic signed [9:0] rs_w;
  logic [OUT_W-1:0]  sat_w;
  logic              round_up_w;
  logic [MW-1:0]     rnd_w;
  logic [MW-1:0]     signed_w;

  // Operand decode, saturation value and rounding arithmetic.
  always_comb begin
    sign_w     = z_q[31];
    exp_w      = z_q[30:23];
    frac_w     = z_q[22:0];
    e_w        = $signed({2'b00, exp_w}) - 10'sd127;
    rs_w       = E_23 - e_w;
    sat_w      = sign_w ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    round_up_w = guard_q && (sticky_q || mag_q[0]);
    rnd_w      = mag_q + {{(MW-1){1'b0}}, round_up_w};
    signed_w   = sign_w ? (~rnd_w + {{(MW-1){1'b0}}, 1'b1}) : rnd_w;
  end

  // Next-state and datapath control for the accept/classify/shift/round/done sequence.
  always_comb begin
    state_d      = state_q;
    z_d          = z_q;
    mag_d        = mag_q;
    guard_d      = guard_q;
    sticky_d     = sticky_q;
    left_d       = left_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    out_int_d    = out_int_q;
    out_status_d = out_status_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          z_d      = bus.in_z;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          state_d  = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        mag_d = {{(MW-24){1'b0}}, 1'b1, frac_w};
        if (exp_w == 8'hFF && frac_w != 23'd0) begin
          out_int_d = '0;
          out_status_d = 2'b11;
          state_d = S_DONE;
        end else if (exp_w == 8'hFF) begin
          out_int_d = sat_w;
          out_status_d = 2'b01;
          state_d = S_DONE;
        end else if (exp_w == 8'h00) begin
          // Zero is exact; denormals are nonzero but round to zero.
          out_int_d = '0;
          out_status_d = (frac_w == 23'd0) ? 2'b00 : 2'b10;
          state_d = S_DONE;
        end else if (e_w > E_TOP) begin
          out_int_d = sat_w;
          out_status_d = 2'b01;
          state_d = S_DONE;
        end else if (e_w == E_TOP) begin
          // Only -2^(OUT_W-1) itself is representable at this exponent.
          out_int_d = sat_w;
          out_status_d = (sign_w && frac_w == 23'd0) ? 2'b00 : 2'b01;
          state_d = S_DONE;
        end else if (e_w >= E_23) begin
          left_d  = 1'b1;
          cnt_d   = 5'(e_w - E_23);
          state_d = (e_w == E_23) ? S_ROUND : S_SHIFT;
        end else begin
          // Beyond 25 right shifts everything already sits in guard/sticky.
          left_d  = 1'b0;
          cnt_d   = (rs_w > 10'sd25) ? 5'd25 : 5'(rs_w);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[MW-2:0], 1'b0};
        end else begin
          mag_d    = {1'b0, mag_q[MW-1:1]};
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_ROUND;
      end
      S_ROUND: begin
        out_int_d    = signed_w[OUT_W-1:0];
        out_status_d = (guard_q | sticky_q) ? 2'b10 : 2'b00;
        state_d      = S_DONE;
      end
      S_DONE: begin
        // out_valid trails entry into DONE by one edge, so the handshake
        // only completes once the result has actually been presented.
        if (out_valid_q && bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      z_q          <= '0;
      mag_q        <= '0;
      guard_q      <= 1'b0;
      sticky_q     <= 1'b0;
      left_q       <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_int_q    <= '0;
      out_status_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      z_q          <= z_d;
      mag_q        <= mag_d;
      guard_q      <= guard_d;
      sticky_q     <= sticky_d;
      left_q       <= left_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_int_q    <= out_int_d;
      out_status_q <= out_status_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_int    = out_int_q;
  assign bus.out_status = out_status_q;
endmodule

// File: tb/tb_float_to_int_converter.sv
// tb/tb_float_to_int_converter.sv - directed bench for float_to_int_converter
module tb_float_to_int_converter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  float_to_int_if #(.OUT_W(32)) bus ();

  float_to_int_converter #(.OUT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Edges from the accept edge until out_valid is seen high; caller sits #1 after the accept edge.
  task automatic wait_out(input string tag, output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat = lat + 1;
      #1;
    end
    if (bus.out_valid !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_ovalid_after_take"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_iready_after_take"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] z, input logic [1:0] flag,
                        input logic [31:0] exp_int, input logic [1:0] exp_st, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.in_z = z;
    bus.in_flag = flag;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_out(tag, lat);
    if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_int"}, bus.out_int, exp_int);
    check({tag, "_status"}, {30'd0, bus.out_status}, {30'd0, exp_st});
    take(tag);
  endtask

  initial begin
    int lat;
    logic ok;
    bus.in_valid = 1'b0;
    bus.in_z = 32'd0;
    bus.in_flag = 2'b00;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_int", bus.out_int, 32'd0);
    check("rst_out_status", {30'd0, bus.out_status}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("r1_5",   32'h3FC00000, 2'b00, 32'h00000002, 2'b10, 26);
    run_op("r2_5",   32'h40200000, 2'b00, 32'h00000002, 2'b10, 25);
    run_op("r0_75",  32'h3F400000, 2'b00, 32'h00000001, 2'b10, 27);
    run_op("r0_5",   32'h3F000000, 2'b00, 32'h00000000, 2'b10, 27);
    run_op("m123",   32'hC2F60000, 2'b00, 32'hFFFFFF85, 2'b00, 20);
    run_op("p1e9",   32'h4E6E6B28, 2'b00, 32'h3B9ACA00, 2'b00, 9);
    run_op("p2p31",  32'h4F000000, 2'b00, 32'h7FFFFFFF, 2'b01, 2);
    run_op("m2p31",  32'hCF000000, 2'b00, 32'h80000000, 2'b00, 2);
    run_op("pinf",   32'h7F800000, 2'b11, 32'h7FFFFFFF, 2'b01, 2);
    run_op("minf",   32'hFF800000, 2'b01, 32'h80000000, 2'b01, 2);
    run_op("nan",    32'h7FC00000, 2'b00, 32'h00000000, 2'b11, 2);
    run_op("zero",   32'h00000000, 2'b00, 32'h00000000, 2'b00, 2);
    run_op("denorm", 32'h80000001, 2'b10, 32'h00000000, 2'b10, 2);
    run_op("m3_0",   32'hC0400000, 2'b00, 32'hFFFFFFFD, 2'b00, 25);

    // Backpressure with in_valid held high the whole time.
    @(negedge clk);
    bus.in_z = 32'h3FC00000;
    bus.in_flag = 2'b00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    wait_out("bp", lat);
    check("bp_latency", lat, 26);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ok = (bus.out_int === 32'h00000002) && (bus.out_status === 2'b10) &&
           (bus.in_ready === 1'b0) && (bus.out_valid === 1'b1);
      check("bp_hold_stable", {31'd0, ok}, 32'd1);
    end
    take("bp");
    @(posedge clk);
    #1;
    check("bp_second_accept", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    wait_out("bp2", lat);
    check("bp2_latency", lat, 26);
    check("bp2_int", bus.out_int, 32'h00000002);
    check("bp2_status", {30'd0, bus.out_status}, 32'd2);
    take("bp2");

    // Reset while shifting -123.0.
    @(negedge clk);
    bus.in_z = 32'hC2F60000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("arst_out_int", bus.out_int, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_1_0", 32'h3F800000, 2'b00, 32'h00000001, 2'b00, 26);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
